// File: rtl/snake_game_sequencer.sv
// Snake game sequencer: owns the game state bus, the move tick and the snake
// length. Walks START -> LOAD -> PLAY1..3 -> WIN/DEAD. Every game decision is
// taken in the cycle where move_tick is high.
// Optional build macro: SNAKE_PAUSE_EN adds btn_pause / paused.
module snake_game_sequencer #(
    parameter int TICK_NORMAL = 25000000,
    parameter int TICK_FAST   = 12500000,
    parameter int TICK_SLOW   = 50000000,
    parameter int FAST_MOVES  = 40,
    parameter int INIT_LEN    = 3,
    parameter int WIN_LEN     = 20
) (
    input  logic       clk_crystal,
    input  logic       rst_global,
    input  logic       btn_start,
    input  logic       hit_wall,
    input  logic       hit_body,
    input  logic       hit_obstacle,
    input  logic       ate,
    input  logic       accelerate,
    input  logic       poisoning,
`ifdef SNAKE_PAUSE_EN
    input  logic       btn_pause,
    output logic       paused,
`endif
    output logic [2:0] state,
    output logic       move_tick,
    output logic       level_load,
    output logic [4:0] snakelength,
    output logic       boosted
);

    localparam int TMAX = (TICK_SLOW > TICK_NORMAL) ?
                          ((TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST) :
                          ((TICK_NORMAL > TICK_FAST) ? TICK_NORMAL : TICK_FAST);
    localparam int CW = $clog2(TMAX) + 1;
    localparam int FW = $clog2(FAST_MOVES + 1);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_PLAY1 = 3'd1,
        ST_PLAY2 = 3'd2,
        ST_PLAY3 = 3'd3,
        ST_DEAD  = 3'd4,
        ST_WIN   = 3'd5,
        ST_LOAD  = 3'd6
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_target, w_target_nxt;
    logic [4:0]      r_len, w_len_nxt, w_len_inc;
    logic [FW-1:0]   r_fast, w_fast_nxt;
    logic [CW-1:0]   r_cnt, w_per_m1;
    logic            r_tick, r_load, r_boost;
    logic            w_play, w_hit, w_paused_nxt;

    assign w_play    = (r_state == ST_PLAY1) || (r_state == ST_PLAY2) || (r_state == ST_PLAY3);
    assign w_hit     = hit_wall | hit_body | hit_obstacle;
    assign w_len_inc = (r_len >= 5'(WIN_LEN)) ? 5'(WIN_LEN) : r_len + 5'd1;

    // Next-state / decision logic; decisions only act on a move tick
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_len_nxt    = r_len;
        w_fast_nxt   = r_fast;
        case (r_state)
            ST_START: if (btn_start) begin
                w_target_nxt = 2'd1;
                w_state_nxt  = ST_LOAD;
            end
            ST_DEAD, ST_WIN: if (btn_start) w_state_nxt = ST_START;
            ST_LOAD: begin
                w_len_nxt   = 5'(INIT_LEN);
                w_fast_nxt  = '0;
                w_state_nxt = state_t'({1'b0, r_target});
            end
            ST_PLAY1, ST_PLAY2, ST_PLAY3: if (r_tick) begin
                if (w_hit) begin
                    w_state_nxt = ST_DEAD;
                end else if (ate) begin
                    w_len_nxt = w_len_inc;
                    if (w_len_inc == 5'(WIN_LEN)) begin
                        if (r_state == ST_PLAY3) begin
                            w_state_nxt = ST_WIN;
                        end else begin
                            w_target_nxt = r_target + 2'd1;
                            w_state_nxt  = ST_LOAD;
                        end
                    end
                end
                // boost bookkeeping runs even on a fatal move
                if (accelerate)          w_fast_nxt = FW'(FAST_MOVES);
                else if (r_fast != '0)   w_fast_nxt = r_fast - 1'b1;
            end
            default: w_state_nxt = ST_START;
        endcase
    end

`ifdef SNAKE_PAUSE_EN
    logic r_paused;

    // Pause toggles only while playing; any level/game boundary clears it
    always_comb begin
        w_paused_nxt = r_paused;
        if (w_play && btn_pause) w_paused_nxt = ~r_paused;
        if (r_state == ST_LOAD || w_state_nxt == ST_DEAD || w_state_nxt == ST_WIN)
            w_paused_nxt = 1'b0;
    end

    // Pause flag register
    always_ff @(posedge clk_crystal) begin
        if (rst_global) r_paused <= 1'b0;
        else            r_paused <= w_paused_nxt;
    end

    assign paused = r_paused;
`else
    assign w_paused_nxt = 1'b0;
`endif

    // Move period: poison beats boost beats normal
    always_comb begin
        w_per_m1 = CW'(TICK_NORMAL - 1);
        if (poisoning)         w_per_m1 = CW'(TICK_SLOW - 1);
        else if (r_fast != '0) w_per_m1 = CW'(TICK_FAST - 1);
    end

    // Game state and datapath registers
    always_ff @(posedge clk_crystal) begin
        if (rst_global) begin
            r_state  <= ST_START;
            r_target <= 2'd1;
            r_len    <= 5'(INIT_LEN);
            r_fast   <= '0;
            r_boost  <= 1'b0;
            r_load   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_len    <= w_len_nxt;
            r_fast   <= w_fast_nxt;
            r_boost  <= (w_fast_nxt != '0);
            r_load   <= (w_state_nxt == ST_LOAD);
        end
    end

    // Tick generator; >= makes a shortened period fire at once instead of wrapping.
    // Freezing on the next pause value keeps move_tick low for the whole pause.
    always_ff @(posedge clk_crystal) begin
        if (rst_global || !w_play) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_paused_nxt) begin
            r_tick <= 1'b0;
        end else if (r_cnt >= w_per_m1) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign state       = r_state;
    assign move_tick   = r_tick;
    assign level_load  = r_load;
    assign snakelength = r_len;
    assign boosted     = r_boost;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Bench for snake_game_sequencer: directed scenario tasks plus a randomized
// run, with a cycle-level game model compared against the DUT every cycle.
module tb_snake_game_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_start = 0, hit_wall = 0, hit_body = 0, hit_obstacle = 0;
    logic ate = 0, accelerate = 0, poisoning = 0, btn_pause = 0;
    logic [2:0] state;
    logic       move_tick, level_load, boosted;
    logic [4:0] snakelength;
`ifdef SNAKE_PAUSE_EN
    logic       paused;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 0;

    always #5 clk = ~clk;

    snake_game_sequencer #(
        .TICK_NORMAL(4), .TICK_FAST(2), .TICK_SLOW(8), .FAST_MOVES(3),
        .INIT_LEN(3), .WIN_LEN(20)
    ) dut (
        .clk_crystal(clk), .rst_global(rst), .btn_start(btn_start),
        .hit_wall(hit_wall), .hit_body(hit_body), .hit_obstacle(hit_obstacle),
        .ate(ate), .accelerate(accelerate), .poisoning(poisoning),
`ifdef SNAKE_PAUSE_EN
        .btn_pause(btn_pause), .paused(paused),
`endif
        .state(state), .move_tick(move_tick), .level_load(level_load),
        .snakelength(snakelength), .boosted(boosted)
    );

    // ---------------- game model (spec rules, plain ints) ----------------
    // phase: 0 start, 1..3 level, 4 dead, 5 win, 6 load
    int m_phase = 0, m_len = 3, m_boost_left = 0, m_level = 1, m_age = 0;
    bit m_tick = 0, m_load = 0, m_paused = 0;

    always @(posedge clk) begin : model
        int ph, ln, bl, lv, spacing;
        bit pz, in_level;
        if (rst) begin
            m_phase = 0; m_len = 3; m_boost_left = 0; m_level = 1; m_age = 0;
            m_tick = 0; m_load = 0; m_paused = 0;
        end else begin
            ph = m_phase; ln = m_len; bl = m_boost_left; lv = m_level; pz = m_paused;
            in_level = (m_phase >= 1 && m_phase <= 3);
`ifdef SNAKE_PAUSE_EN
            if (in_level && btn_pause) pz = !pz;
`endif
            if (m_phase == 0) begin
                if (btn_start) begin lv = 1; ph = 6; end
            end else if (m_phase == 4 || m_phase == 5) begin
                if (btn_start) ph = 0;
            end else if (m_phase == 6) begin
                ln = 3; bl = 0; ph = m_level;
            end else if (m_tick) begin
                if (hit_wall || hit_body || hit_obstacle) ph = 4;
                else if (ate) begin
                    ln = (m_len + 1 > 20) ? 20 : m_len + 1;
                    if (ln == 20) begin
                        if (m_phase == 3) ph = 5;
                        else begin lv = m_level + 1; ph = 6; end
                    end
                end
                if (accelerate) bl = 3;
                else if (bl > 0) bl = bl - 1;
            end
            if (m_phase == 6 || ph == 4 || ph == 5) pz = 0;
            // move spacing chosen by the speed effect active this cycle
            spacing = poisoning ? 8 : (m_boost_left > 0 ? 2 : 4);
            m_tick = 0;
            if (!in_level) m_age = 0;
            else if (!pz) begin
                if (m_age + 1 >= spacing) begin m_age = 0; m_tick = 1; end
                else m_age = m_age + 1;
            end
            m_phase = ph; m_len = ln; m_boost_left = bl; m_level = lv; m_paused = pz;
            m_load = (ph == 6);
        end
    end

    // Every-cycle scoreboard against the model
    always @(negedge clk) begin
        logic [10:0] dv, mv;
        if (mon_en) begin
            dv = {state, move_tick, level_load, snakelength, boosted};
            mv = {3'(m_phase), m_tick, m_load, 5'(m_len), (m_boost_left > 0)};
            n_cmp++;
            if (dv !== mv) begin
                n_fail++;
                $display("FAIL model t=%0t {state,tick,load,len,boost} got=%h want=%h", $time, dv, mv);
            end
`ifdef SNAKE_PAUSE_EN
            n_cmp++;
            if (paused !== m_paused) begin
                n_fail++;
                $display("FAIL model_paused t=%0t got=%b want=%b", $time, paused, m_paused);
            end
`endif
        end
    end

    // ---------------- stimulus helpers (no checks) ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1; btn_start = 0; hit_wall = 0; hit_body = 0; hit_obstacle = 0;
        ate = 0; accelerate = 0; poisoning = 0; btn_pause = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic start_game();
        @(negedge clk); btn_start = 1;
        @(negedge clk); btn_start = 0;
        @(negedge clk);
    endtask

    // Returns cycles until the next move_tick; a timeout is counted as a failure
    task automatic wait_tick(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (move_tick !== 1'b1 && n < 40);
        if (move_tick !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL tick_timeout waited=%0d cycles, no move_tick", n);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        @(negedge clk); rst = 1;
        repeat (3) @(negedge clk);
        n_cmp++; if (state !== 3'd0)       begin n_fail++; $display("FAIL rst_state got=%0d want=0", state); end
        n_cmp++; if (snakelength !== 5'd3) begin n_fail++; $display("FAIL rst_len got=%0d want=3", snakelength); end
        n_cmp++; if ({move_tick, level_load, boosted} !== 3'b000)
            begin n_fail++; $display("FAIL rst_flags got=%b want=000", {move_tick, level_load, boosted}); end
        rst = 0;
        mon_en = 1;
    endtask

    task automatic test_start();
        int n;
        @(negedge clk); btn_start = 1;
        @(negedge clk); btn_start = 0;
        n_cmp++; if (state !== 3'd6 || level_load !== 1'b1)
            begin n_fail++; $display("FAIL load_cycle got state=%0d load=%b want 6/1", state, level_load); end
        @(negedge clk);
        n_cmp++; if (state !== 3'd1 || level_load !== 1'b0 || snakelength !== 5'd3)
            begin n_fail++; $display("FAIL play1_entry got state=%0d load=%b len=%0d want 1/0/3", state, level_load, snakelength); end
        wait_tick(n);
        n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL first_tick got=%0d want=4", n); end
        wait_tick(n);
        n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL tick_spacing got=%0d want=4", n); end
    endtask

    task automatic test_eat_levels();
        int n;
        do_reset(); start_game();
        for (int lvl = 1; lvl <= 3; lvl++) begin
            if (lvl == 2) begin
                @(negedge clk); btn_start = 1;
                @(negedge clk); btn_start = 0;
                n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL start_in_play got=%0d want=2", state); end
            end
            ate = 1;
            repeat (17) wait_tick(n);
            n_cmp++; if (snakelength !== 5'd19) begin n_fail++; $display("FAIL len_before_win lvl=%0d got=%0d want=19", lvl, snakelength); end
            @(negedge clk); ate = 0;
            if (lvl < 3) begin
                n_cmp++; if (state !== 3'd6 || snakelength !== 5'd20 || level_load !== 1'b1)
                    begin n_fail++; $display("FAIL level_done lvl=%0d got state=%0d len=%0d want 6/20", lvl, state, snakelength); end
                @(negedge clk);
                n_cmp++; if (state !== 3'(lvl + 1) || snakelength !== 5'd3)
                    begin n_fail++; $display("FAIL next_level got state=%0d len=%0d want %0d/3", state, snakelength, lvl + 1); end
            end else begin
                n_cmp++; if (state !== 3'd5 || snakelength !== 5'd20)
                    begin n_fail++; $display("FAIL win got state=%0d len=%0d want 5/20", state, snakelength); end
            end
        end
        @(negedge clk); btn_start = 1;
        @(negedge clk); btn_start = 0;
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL win_restart got=%0d want=0", state); end
    endtask

    task automatic test_collision();
        int n;
        do_reset(); start_game();
        wait_tick(n);
        @(negedge clk); hit_wall = 1;
        @(negedge clk); hit_wall = 0;
        wait_tick(n);
        n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL wall_off_tick got=%0d want=1", state); end
        hit_body = 1; ate = 1;
        @(negedge clk); hit_body = 0; ate = 0;
        n_cmp++; if (state !== 3'd4 || snakelength !== 5'd3)
            begin n_fail++; $display("FAIL body_hit got state=%0d len=%0d want 4/3", state, snakelength); end
        repeat (6) @(negedge clk);
        n_cmp++; if (move_tick !== 1'b0 || state !== 3'd4)
            begin n_fail++; $display("FAIL dead_idle got tick=%b state=%0d want 0/4", move_tick, state); end
    endtask

    task automatic test_boost();
        int n;
        do_reset(); start_game();
        wait_tick(n);
        accelerate = 1;
        @(negedge clk); accelerate = 0;
        n_cmp++; if (boosted !== 1'b1) begin n_fail++; $display("FAIL boost_on got=%b want=1", boosted); end
        wait_tick(n);
        n_cmp++; if (n + 1 !== 2) begin n_fail++; $display("FAIL boost_gap1 got=%0d want=2", n + 1); end
        wait_tick(n);
        n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL boost_gap2 got=%0d want=2", n); end
        wait_tick(n);
        n_cmp++; if (n !== 2 || boosted !== 1'b1) begin n_fail++; $display("FAIL boost_gap3 got=%0d/%b want=2/1", n, boosted); end
        wait_tick(n);
        n_cmp++; if (n !== 4 || boosted !== 1'b0) begin n_fail++; $display("FAIL boost_end got=%0d/%b want=4/0", n, boosted); end
        accelerate = 1; poisoning = 1;
        @(negedge clk); accelerate = 0;
        wait_tick(n);
        n_cmp++; if (n + 1 !== 8) begin n_fail++; $display("FAIL poison_over_boost got=%0d want=8", n + 1); end
        poisoning = 0;
        wait_tick(n);
        n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL boost_after_poison got=%0d want=2", n); end
    endtask

    task automatic test_poison_switch();
        int n;
        do_reset(); start_game();
        wait_tick(n);
        poisoning = 1;
        repeat (5) @(negedge clk);
        n_cmp++; if (move_tick !== 1'b0) begin n_fail++; $display("FAIL slow_hold got=%b want=0", move_tick); end
        poisoning = 0;
        @(negedge clk);
        n_cmp++; if (move_tick !== 1'b1) begin n_fail++; $display("FAIL poison_drop_fire got=%b want=1", move_tick); end
    endtask

    task automatic test_reset_in_load();
        do_reset();
        @(negedge clk); btn_start = 1;
        @(negedge clk); btn_start = 0; rst = 1;
        @(negedge clk); rst = 0;
        n_cmp++; if (state !== 3'd0 || level_load !== 1'b0)
            begin n_fail++; $display("FAIL reset_in_load got state=%0d load=%b want 0/0", state, level_load); end
    endtask

`ifdef SNAKE_PAUSE_EN
    task automatic test_pause();
        int n;
        do_reset(); start_game();
        ate = 1; repeat (17) wait_tick(n);
        @(negedge clk); ate = 0;
        @(negedge clk);
        wait_tick(n);
        @(negedge clk); btn_pause = 1;
        @(negedge clk); btn_pause = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (move_tick !== 1'b0 || state !== 3'd2 || paused !== 1'b1)
                begin n_fail++; $display("FAIL paused_hold i=%0d got tick=%b state=%0d", i, move_tick, state); end
        end
        btn_pause = 1;
        @(negedge clk); btn_pause = 0;
        wait_tick(n);
        n_cmp++; if (n + 1 !== 3) begin n_fail++; $display("FAIL pause_resume got=%0d want=3", n + 1); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 599) == 0);
            btn_start    = ($urandom_range(0, 19) == 0);
            hit_wall     = ($urandom_range(0, 79) == 0);
            hit_body     = ($urandom_range(0, 79) == 0);
            hit_obstacle = ($urandom_range(0, 79) == 0);
            ate          = ($urandom_range(0, 1) == 0);
            accelerate   = ($urandom_range(0, 11) == 0);
            btn_pause    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) poisoning = ~poisoning;
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_start();
        test_eat_levels();
        test_collision();
        test_boost();
        test_poison_switch();
        test_reset_in_load();
`ifdef SNAKE_PAUSE_EN
        test_pause();
`endif
        test_random();
        @(negedge clk);
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_game_sequencer.md
Name: snake_game_sequencer

Overview:
- Top-level game controller for the snake datapath.
- Owns the game `state` bus consumed by the image/region logic, the snake move tick, and `snakelength`.
- Sequences START -> level 1..3 -> WIN/DEAD, and converts collision/eat/speed events from the image logic into state, length and tick-rate changes.
- Only the move tick lets the snake advance; every game decision is taken on a move tick.

Parameters:
- TICK_NORMAL, 25000000: clock cycles per move at normal speed (4 moves/s at 100 MHz).
- TICK_FAST, 12500000: cycles per move while boosted.
- TICK_SLOW, 50000000: cycles per move while poisoned.
- FAST_MOVES, 40: number of moves one boost lasts.
- INIT_LEN, 3: snake length loaded at each level start.
- WIN_LEN, 20: length that completes a level; must be <= 20.

Ports:
- clk_crystal  in  1  system clock.
- rst_global  in  1  synchronous, active-high reset.
- btn_start  in  1  debounced one-cycle start/continue pulse.
- hit_wall  in  1  head's next move leaves the map.
- hit_body  in  1  head's next cell is an enabled body part.
- hit_obstacle  in  1  head's next cell is an obstacle of the current map.
- ate  in  1  head's next cell is food.
- accelerate  in  1  head's next cell is flash.
- poisoning  in  1  poison slow-down window active.
- state  out  3  game state, encoding below.
- move_tick  out  1  one-cycle pulse: snake advances one cell.
- level_load  out  1  one-cycle pulse: reinitialise snake position, food and obstacles.
- snakelength  out  5  current snake length.
- boosted  out  1  `fast_cnt` != 0.

Behaviour:
- Clock and reset: one clock, `clk_crystal`. `rst_global` is synchronous and active-high.
- State encoding: START=0, PLAY1=1, PLAY2=2, PLAY3=3, DEAD=4, WIN=5, LOAD=6. Code 7 is illegal and recovers to START on the next clock.
- Reset values: state=START, snakelength=INIT_LEN, move_tick=0, level_load=0, boosted=0, tick counter=0, fast_cnt=0, target level=1.
- Reset has priority over every event, including mid-LOAD and mid-tick.
- START: on `btn_start`, target=1 and go to LOAD.
- DEAD, WIN: on `btn_start`, go to START. All other inputs are ignored.
- LOAD (exactly one cycle):
  - `level_load`=1.
  - snakelength <= INIT_LEN; tick counter <= 0; fast_cnt <= 0.
  - Next state = PLAY<target>.
- Tick generator:
  - Runs only in PLAY1..3; held at 0 in other states.
  - Period select: `poisoning` -> TICK_SLOW; else fast_cnt != 0 -> TICK_FAST; else TICK_NORMAL.
  - When counter >= period-1: counter <= 0 and the registered `move_tick` is 1 in the following cycle. Otherwise counter+1.
  - The `>=` compare guarantees a period switch mid-count fires immediately rather than wrapping.
- Move decision, evaluated in the cycle `move_tick`=1, using input values in that cycle, in priority order:
  1. `hit_wall | hit_body | hit_obstacle` -> DEAD. Length unchanged.
  2. Else if `ate`:
     - snakelength+1.
     - If the new length == WIN_LEN: from PLAY1/PLAY2, target+1 and go to LOAD; from PLAY3, go to WIN.
  3. Independently of 2 (same tick), if `accelerate`: fast_cnt <= FAST_MOVES, reloading even if nonzero.
  4. Else if fast_cnt != 0: fast_cnt-1 per move_tick.
- Inputs outside move_tick cycles have no effect.
- snakelength saturates at WIN_LEN. It never wraps.
- `btn_start` during PLAY or LOAD is ignored.
- All outputs are registered.

Optional Feature:
- Macro: SNAKE_PAUSE_EN.
- When defined, adds input `btn_pause` (1-bit, one-cycle pulse) and output `paused` (1-bit, reset 0).
- In PLAY1..3, a `btn_pause` pulse toggles `paused`.
- While `paused`=1:
  - tick counter and fast_cnt freeze;
  - `move_tick` stays 0;
  - `state` is unchanged.
- `paused` clears on LOAD, on DEAD/WIN entry, and on reset.
- When undefined, neither port exists and behaviour is as above.

Test Plan:
- Run with TICK_NORMAL=4, TICK_FAST=2, TICK_SLOW=8, FAST_MOVES=3. Reset, then `btn_start` -> LOAD for 1 cycle with level_load=1, then state=1; move_tick pulses every 4 cycles; snakelength=3.
- PLAY1, `ate` held on 17 consecutive ticks -> length 4..20. At 20: LOAD then state=2, snakelength=3. Repeat in PLAY3 -> state=5; then `btn_start` -> state=0.
- `hit_body`=1 and `ate`=1 on the same tick -> state=4, snakelength unchanged. Pulsing `hit_wall` between ticks -> no effect.
- `accelerate` on a tick -> boosted=1, next 3 tick spacings are 2 cycles, then spacing returns to 4 and boosted=0. `poisoning`=1 during the boost -> spacing 8.
- Counter at 5 under TICK_SLOW when `poisoning` drops -> move_tick fires next cycle. `rst_global` asserted during LOAD -> state=0, level_load=0 next cycle.
- With SNAKE_PAUSE_EN: pause mid-PLAY2 for 20 cycles -> no move_tick, state=2. Unpause -> tick resumes from the frozen counter value.
